// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multicycle MIPS controller and its datapath.
//   master : controller side - reads op/funct/zero/mem_ready, drives all
//            enables, mux selects, ALU control, illegal_op and debug state.
//   slave  : datapath side - the mirror image.
// Signals:
//   op[5:0], funct[5:0]  IR[31:26] / IR[5:0]
//   zero                 ALU zero flag
//   mem_ready            memory access completes this cycle
//   pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst
//   alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal_op, state[3:0]
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, illegal_op, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing the shared multicycle MIPS datapath (single memory,
// single ALU, IR/A/B/ALUOut registers). Supports R-type add/sub/and/or/slt,
// lw, sw, beq, addi and j. Memory states wait on mem_ready.
//
// Parameters:
//   MEM_READY_EN  1: FETCH/MEMRD/MEMWR hold until mem_ready
//                 0: mem_ready ignored (treated as always 1)
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active-high; forces every output to 0
//   io_bus   multicycle_controller_if.master (op/funct/zero/mem_ready in,
//            control enables/selects/alucontrol/illegal_op/state out)
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | FETCH  : read instr at PC, PC+4; hold until mem_ready
//   1   | DECODE : compute branch target, dispatch on op
//   2   | MEMADR : ALUOut = A + signimm
//   3   | MEMRD  : read memory at ALUOut; hold until mem_ready
//   4   | MEMWB  : rt <= MDR
//   5   | MEMWR  : write B to memory at ALUOut; hold until mem_ready
//   6   | EXEC   : ALUOut = A op B
//   7   | ALUWB  : rd <= ALUOut
//   8   | BRANCH : A - B, load PC with target if zero
//   9   | ADDIEX : ALUOut = A + signimm
//  10   | ADDIWB : rt <= ALUOut
//  11   | JUMP   : PC <= jump target
// 12-15 | unused : all outputs 0, back to FETCH
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit MEM_READY_EN = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    multicycle_controller_if.master io_bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic       w_mem_ready;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_alusrca;
    logic       w_iord;
    logic       w_memtoreg;
    logic       w_regdst;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [2:0] w_alucontrol;
    logic       w_illegal_op;

    assign w_mem_ready = MEM_READY_EN ? io_bus.mem_ready : 1'b1;

    // Supported R-type functions and their ALU encodings.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        unique case (io_bus.funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (io_bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = w_funct_ok ? S_EXEC : S_FETCH;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (io_bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output logic. Reset overrides everything, including the mem_ready-driven
    // irwrite/pcwrite of FETCH, so the datapath sees no strobes while held.
    always_comb begin
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_iord       = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_alucontrol = ALU_ADD;
        w_illegal_op = 1'b0;
        if (i_rst) begin
            w_alucontrol = 3'b000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_alusrcb = 2'b01;
                    w_irwrite = w_mem_ready;
                    w_pcwrite = w_mem_ready;
                end
                S_DECODE: begin
                    w_alusrcb = 2'b11;
                    case (io_bus.op)
                        OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_illegal_op = 1'b0;
                        OP_RTYPE: w_illegal_op = ~w_funct_ok;
                        default:  w_illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                end
                S_MEMRD: w_iord = 1'b1;
                S_MEMWB: begin
                    w_memtoreg = 1'b1;
                    w_regwrite = 1'b1;
                end
                S_MEMWR: begin
                    w_iord     = 1'b1;
                    w_memwrite = 1'b1;
                end
                S_EXEC: begin
                    w_alusrca    = 1'b1;
                    w_alucontrol = w_funct_alu;
                end
                S_ALUWB: begin
                    w_regdst   = 1'b1;
                    w_regwrite = 1'b1;
                end
                S_BRANCH: begin
                    w_alusrca    = 1'b1;
                    w_alucontrol = ALU_SUB;
                    w_branch     = 1'b1;
                    w_pcsrc      = 2'b01;
                end
                S_ADDIEX: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                end
                S_ADDIWB: w_regwrite = 1'b1;
                S_JUMP: begin
                    w_pcsrc   = 2'b10;
                    w_pcwrite = 1'b1;
                end
                default: w_alucontrol = 3'b000;
            endcase
        end
    end

    assign io_bus.pcen       = w_pcwrite | (w_branch & io_bus.zero);
    assign io_bus.memwrite   = w_memwrite;
    assign io_bus.irwrite    = w_irwrite;
    assign io_bus.regwrite   = w_regwrite;
    assign io_bus.alusrca    = w_alusrca;
    assign io_bus.iord       = w_iord;
    assign io_bus.memtoreg   = w_memtoreg;
    assign io_bus.regdst     = w_regdst;
    assign io_bus.alusrcb    = w_alusrcb;
    assign io_bus.pcsrc      = w_pcsrc;
    assign io_bus.alucontrol = w_alucontrol;
    assign io_bus.illegal_op = w_illegal_op;
    assign io_bus.state      = r_state;

endmodule
